// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared types, note table and half-period helper for the tone controller
package tone_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP
    } tone_state_t;

    localparam int REF_OCTAVE   = 4;
    localparam int CNT_OVERHEAD = 3;

    // Octave-4 note frequencies in centi-Hz, C4 .. B4
    localparam int NOTE_FREQ_CHZ [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                                          36999, 39200, 41530, 44000, 46616, 49388};

    // Each division has constant operands, so the loop folds into a small constant table
    function automatic logic [31:0] half_period(input longint unsigned clk_hz,
                                                input logic [3:0]      note,
                                                input logic [2:0]      octave);
        longint unsigned base;
        base = 0;
        for (int i = 0; i < 12; i++) begin
            if (note == 4'(i + 1)) begin
                base = (clk_hz * 50) / 64'(NOTE_FREQ_CHZ[i]);
            end
        end
        if (octave < 3'(REF_OCTAVE)) begin
            base = base << (REF_OCTAVE - int'(octave));
        end else begin
            base = base >> (int'(octave) - REF_OCTAVE);
        end
        return base[31:0];
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler with a one-cycle tick and synchronous clear
module ms_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic clear,
    output logic tick
);

    localparam int DIV = CLK_HZ / 1000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tone_controller.sv
// rtl/tone_controller.sv - note sequencer driving the limit/enable tone counter and speaker output
// Optional post-note silence is enabled with TONE_GAP_EN.
module tone_controller
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int GAP_MS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [3:0]  note_code,
    input  logic [2:0]  octave,
    input  logic [15:0] duration_ms,
    output logic        cnt_reset,
    output logic [31:0] cnt_limit,
    output logic        cnt_limit_we,
    output logic        cnt_enable,
    input  logic        cnt_limit_reached,
    output logic        speaker,
    output logic        busy
);

`ifdef TONE_GAP_EN
    localparam tone_state_t AFTER_NOTE = S_GAP;
`else
    localparam tone_state_t AFTER_NOTE = S_IDLE;
`endif

    tone_state_t state, state_next;

    logic        tone_q;
    logic [15:0] dur_q;
    logic [15:0] dur_cnt;
    logic [31:0] cnt_limit_q;
    logic        speaker_q;
    logic        ms_tick;
    logic        ms_clear;
    logic        ms_hit;
    logic [15:0] ms_target;
    logic        accept;
    logic        tone_in;

    assign note_ready = (state == S_IDLE) && !reset;
    assign busy       = (state != S_IDLE);
    assign accept     = note_valid && note_ready;
    assign tone_in    = (note_code >= 4'd1) && (note_code <= 4'd12);
    assign cnt_limit  = cnt_limit_q;
    assign speaker    = speaker_q;

    // The same ms counter times both the note and the gap
    assign ms_target = (state == S_GAP) ? 16'(GAP_MS) : dur_q;
    assign ms_hit    = ms_tick && (({1'b0, dur_cnt} + 17'd1) == {1'b0, ms_target});
    assign ms_clear  = reset || (state == S_IDLE) || (state == S_LOAD) ||
                       ((state == S_RUN) && ms_hit);

    ms_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_ms_tick (
        .clk  (clk),
        .clear(ms_clear),
        .tick (ms_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_reset    = 1'b1;
        cnt_enable   = 1'b0;
        cnt_limit_we = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    if (accept) state_next = S_LOAD;
                end
                S_LOAD: begin
                    cnt_limit_we = tone_q && (dur_q != 16'd0);
                    state_next   = (dur_q == 16'd0) ? AFTER_NOTE : S_RUN;
                end
                S_RUN: begin
                    // Expiry overrides a coincident limit hit: counter stays reset, no toggle
                    if (ms_hit) begin
                        state_next = AFTER_NOTE;
                    end else begin
                        cnt_reset  = cnt_limit_reached;
                        cnt_enable = tone_q && !cnt_limit_reached;
                    end
                end
                S_GAP: begin
                    if (ms_hit) state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tone_q      <= 1'b0;
            dur_q       <= '0;
            dur_cnt     <= '0;
            cnt_limit_q <= '0;
            speaker_q   <= 1'b0;
        end else begin
            if (accept) begin
                tone_q <= tone_in;
                dur_q  <= duration_ms;
                if (tone_in && (duration_ms != 16'd0)) begin
                    cnt_limit_q <= half_period(64'(CLK_HZ), note_code, octave) - 32'(CNT_OVERHEAD);
                end
            end
            if (ms_clear) begin
                dur_cnt <= '0;
            end else if (ms_tick) begin
                dur_cnt <= dur_cnt + 16'd1;
            end
            if (state == S_RUN && !ms_hit) begin
                if (tone_q && cnt_limit_reached) speaker_q <= ~speaker_q;
            end else begin
                speaker_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tone_controller.sv
// tb/tb_tone_controller.sv - self-checking bench for tone_controller with an attached limit counter
module tb_tone_controller;

    localparam int CLK_HZ = 1_000_000;
    localparam int GAP_MS = 1;
    localparam int MS     = CLK_HZ / 1000;
`ifdef TONE_GAP_EN
    localparam int GAP_CYC = GAP_MS * MS;
`else
    localparam int GAP_CYC = 0;
`endif
    localparam int FREQ [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                                 36999, 39200, 41530, 44000, 46616, 49388};

    logic        clk = 1'b0;
    logic        reset;
    logic        note_valid;
    logic        note_ready;
    logic [3:0]  note_code;
    logic [2:0]  octave;
    logic [15:0] duration_ms;
    logic        cnt_reset;
    logic [31:0] cnt_limit;
    logic        cnt_limit_we;
    logic        cnt_enable;
    logic        cnt_limit_reached;
    logic        speaker;
    logic        busy;

    always #5 clk = ~clk;

    tone_controller #(
        .CLK_HZ(CLK_HZ),
        .GAP_MS(GAP_MS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .note_valid       (note_valid),
        .note_ready       (note_ready),
        .note_code        (note_code),
        .octave           (octave),
        .duration_ms      (duration_ms),
        .cnt_reset        (cnt_reset),
        .cnt_limit        (cnt_limit),
        .cnt_limit_we     (cnt_limit_we),
        .cnt_enable       (cnt_enable),
        .cnt_limit_reached(cnt_limit_reached),
        .speaker          (speaker),
        .busy             (busy)
    );

    // Limit counter: sticky limit_reached once the count has passed the limit
    logic [31:0] c_limit, c_count;
    always @(posedge clk) begin
        if (reset) c_limit <= 32'd0;
        else if (cnt_limit_we) c_limit <= cnt_limit;
        if (reset || cnt_reset) begin
            c_count           <= 32'd0;
            cnt_limit_reached <= 1'b0;
        end else if (cnt_enable) begin
            c_count <= c_count + 32'd1;
            if (c_count > c_limit) cnt_limit_reached <= 1'b1;
        end
    end

    typedef struct packed {
        int   limit;
        int   toggles;
        int   first_t;
        int   last_t;
        int   end_k;
        int   busy_cycles;
        int   wait_cycles;
        logic we;
        logic en_seen;
        logic spk_end;
        logic overlap;
        logic timeout;
        logic rst_spk;
        logic rst_cr;
        logic rst_busy;
        logic rst_ready;
        logic ready_after;
    } res_t;

    int checks = 0;
    int errors = 0;

    function automatic int model_limit(input int n, input int o);
        longint b;
        b = (64'(CLK_HZ) * 50) / 64'(FREQ[n-1]);
        if (o < 4) b = b << (4 - o);
        else b = b >> (o - 4);
        return int'(b) - 3;
    endfunction

    // Times are counted in cycles after the LOAD edge; garbage is driven on the inputs mid-note
    task automatic play(input logic [3:0] n, input logic [2:0] o, input logic [15:0] d,
                        input int reset_at, output res_t r);
        logic prev;
        r = '0;
        note_code = n; octave = o; duration_ms = d; note_valid = 1'b1;
        while (!note_ready && r.wait_cycles < 20000) begin
            @(negedge clk);
            r.wait_cycles++;
        end
        if (!note_ready) begin
            r.timeout = 1'b1; note_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        note_code = 4'($urandom); octave = 3'($urandom); duration_ms = 16'($urandom);
        note_valid = 1'($urandom);
        @(negedge clk);
        r.we = cnt_limit_we; r.limit = cnt_limit; r.busy_cycles = busy ? 1 : 0;
        prev = speaker;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (k == reset_at) begin
                reset = 1'b1; note_valid = 1'b0;
                @(negedge clk);
                r.rst_spk = speaker; r.rst_cr = cnt_reset; r.rst_busy = busy; r.rst_ready = note_ready;
                reset = 1'b0;
                @(negedge clk);
                r.ready_after = note_ready; r.end_k = k;
                return;
            end
            if (note_ready && busy) r.overlap = 1'b1;
            if (!busy) begin
                r.end_k = k; r.spk_end = speaker; note_valid = 1'b0;
                return;
            end
            r.busy_cycles++;
            r.en_seen = r.en_seen | cnt_enable;
            if (speaker !== prev) begin
                r.toggles++;
                if (r.toggles == 1) r.first_t = k;
                r.last_t = k;
            end
            prev = speaker;
        end
        r.timeout = 1'b1; note_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; note_valid = 1'b0; note_code = 4'd0; octave = 3'd0; duration_ms = 16'd0;
        repeat (3) @(negedge clk);
        checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", note_ready); end
        checks++; if (cnt_reset !== 1'b1) begin errors++; $display("FAIL rst_cnt_reset: got %b want 1", cnt_reset); end
        checks++; if (cnt_enable !== 1'b0) begin errors++; $display("FAIL rst_cnt_enable: got %b want 0", cnt_enable); end
        checks++; if (cnt_limit_we !== 1'b0) begin errors++; $display("FAIL rst_limit_we: got %b want 0", cnt_limit_we); end
        checks++; if (cnt_limit !== 32'd0) begin errors++; $display("FAIL rst_limit: got %0d want 0", cnt_limit); end
        checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL rst_speaker: got %b want 0", speaker); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", note_ready); end
    endtask

    task automatic test_a4_oct4;
        res_t r;
        play(4'd10, 3'd4, 16'd2, -1, r);
        checks++; if (r.timeout !== 1'b0) begin errors++; $display("FAIL a4o4_timeout: got %b want 0", r.timeout); end
        checks++; if (r.we !== 1'b1) begin errors++; $display("FAIL a4o4_we: got %b want 1", r.we); end
        checks++; if (r.limit !== 1133) begin errors++; $display("FAIL a4o4_limit: got %0d want 1133", r.limit); end
        checks++; if (r.toggles !== 1) begin errors++; $display("FAIL a4o4_toggles: got %0d want 1", r.toggles); end
        checks++; if (r.first_t !== 1136) begin errors++; $display("FAIL a4o4_first: got %0d want 1136", r.first_t); end
        checks++; if (r.end_k !== 2000 + GAP_CYC) begin errors++; $display("FAIL a4o4_end: got %0d want %0d", r.end_k, 2000 + GAP_CYC); end
        checks++; if (r.spk_end !== 1'b0) begin errors++; $display("FAIL a4o4_spk_end: got %b want 0", r.spk_end); end
    endtask

    task automatic test_a4_oct5;
        res_t r;
        play(4'd10, 3'd5, 16'd5, -1, r);
        checks++; if (r.limit !== 565) begin errors++; $display("FAIL a4o5_limit: got %0d want 565", r.limit); end
        checks++; if (r.toggles !== 8) begin errors++; $display("FAIL a4o5_toggles: got %0d want 8", r.toggles); end
        checks++; if (r.first_t !== 568) begin errors++; $display("FAIL a4o5_first: got %0d want 568", r.first_t); end
        checks++; if (r.last_t !== 8 * 568) begin errors++; $display("FAIL a4o5_last: got %0d want %0d", r.last_t, 8 * 568); end
        checks++; if (r.end_k !== 5000 + GAP_CYC) begin errors++; $display("FAIL a4o5_end: got %0d want %0d", r.end_k, 5000 + GAP_CYC); end
    endtask

    task automatic test_rest;
        res_t r;
        logic [3:0] codes [2] = '{4'd0, 4'd14};
        for (int i = 0; i < 2; i++) begin
            play(codes[i], 3'd4, 16'd3, -1, r);
            checks++; if (r.we !== 1'b0) begin errors++; $display("FAIL rest%0d_we: got %b want 0", i, r.we); end
            checks++; if (r.en_seen !== 1'b0) begin errors++; $display("FAIL rest%0d_enable: got %b want 0", i, r.en_seen); end
            checks++; if (r.toggles !== 0) begin errors++; $display("FAIL rest%0d_toggles: got %0d want 0", i, r.toggles); end
            checks++; if (r.busy_cycles !== 1 + 3000 + GAP_CYC) begin errors++; $display("FAIL rest%0d_busy: got %0d want %0d", i, r.busy_cycles, 1 + 3000 + GAP_CYC); end
        end
    endtask

    task automatic test_zero_duration;
        res_t r;
        play(4'd10, 3'd4, 16'd0, -1, r);
        checks++; if (r.we !== 1'b0) begin errors++; $display("FAIL zero_we: got %b want 0", r.we); end
        checks++; if (r.end_k !== GAP_CYC) begin errors++; $display("FAIL zero_end: got %0d want %0d", r.end_k, GAP_CYC); end
        checks++; if (r.toggles !== 0) begin errors++; $display("FAIL zero_toggles: got %0d want 0", r.toggles); end
    endtask

    task automatic test_reset_mid_note;
        res_t r;
        play(4'd10, 3'd5, 16'd10, 700, r);
        checks++; if (r.toggles !== 1) begin errors++; $display("FAIL midrst_pre_toggles: got %0d want 1", r.toggles); end
        checks++; if (r.rst_spk !== 1'b0) begin errors++; $display("FAIL midrst_speaker: got %b want 0", r.rst_spk); end
        checks++; if (r.rst_cr !== 1'b1) begin errors++; $display("FAIL midrst_cnt_reset: got %b want 1", r.rst_cr); end
        checks++; if (r.rst_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", r.rst_busy); end
        checks++; if (r.rst_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_in_reset: got %b want 0", r.rst_ready); end
        checks++; if (r.ready_after !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b want 1", r.ready_after); end
    endtask

    task automatic test_back_to_back;
        res_t r1, r2;
        play(4'd1, 3'd4, 16'd1, -1, r1);
        play(4'd12, 3'd6, 16'd1, -1, r2);
        checks++; if (r1.limit !== 1908) begin errors++; $display("FAIL b2b_limit1: got %0d want 1908", r1.limit); end
        checks++; if (r2.limit !== 250) begin errors++; $display("FAIL b2b_limit2: got %0d want 250", r2.limit); end
        checks++; if (r2.toggles !== 3) begin errors++; $display("FAIL b2b_toggles2: got %0d want 3", r2.toggles); end
        checks++; if (r1.overlap !== 1'b0) begin errors++; $display("FAIL b2b_ready_while_busy: got %b want 0", r1.overlap); end
        checks++; if (r2.wait_cycles !== 0) begin errors++; $display("FAIL b2b_wait: got %0d want 0", r2.wait_cycles); end
    endtask

    task automatic test_random;
        res_t r;
        int n, o, d, p, exp_t;
        logic tone;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 15); o = $urandom_range(0, 7); d = $urandom_range(0, 2);
            tone = (n >= 1 && n <= 12);
            play(4'(n), 3'(o), 16'(d), -1, r);
            p = tone ? model_limit(n, o) + 3 : 1;
            exp_t = (tone && d > 0) ? (d * MS - 1) / p : 0;
            checks++; if (r.we !== (tone && d != 0)) begin errors++; $display("FAIL rnd%0d_we: got %b want %b (n=%0d o=%0d d=%0d)", it, r.we, tone && d != 0, n, o, d); end
            if (tone && d != 0) begin
                checks++; if (r.limit !== p - 3) begin errors++; $display("FAIL rnd%0d_limit: got %0d want %0d", it, r.limit, p - 3); end
                checks++; if (r.en_seen !== 1'b1) begin errors++; $display("FAIL rnd%0d_enable: got %b want 1", it, r.en_seen); end
            end else begin
                checks++; if (r.en_seen !== 1'b0) begin errors++; $display("FAIL rnd%0d_enable: got %b want 0", it, r.en_seen); end
            end
            checks++; if (r.toggles !== exp_t) begin errors++; $display("FAIL rnd%0d_toggles: got %0d want %0d", it, r.toggles, exp_t); end
            if (exp_t > 0) begin
                checks++; if (r.first_t !== p) begin errors++; $display("FAIL rnd%0d_first: got %0d want %0d", it, r.first_t, p); end
                checks++; if (r.last_t !== exp_t * p) begin errors++; $display("FAIL rnd%0d_last: got %0d want %0d", it, r.last_t, exp_t * p); end
            end
            checks++; if (r.end_k !== d * MS + GAP_CYC) begin errors++; $display("FAIL rnd%0d_end: got %0d want %0d", it, r.end_k, d * MS + GAP_CYC); end
            checks++; if (r.busy_cycles !== 1 + d * MS + GAP_CYC) begin errors++; $display("FAIL rnd%0d_busy: got %0d want %0d", it, r.busy_cycles, 1 + d * MS + GAP_CYC); end
            checks++; if (r.spk_end !== 1'b0) begin errors++; $display("FAIL rnd%0d_spk_end: got %b want 0", it, r.spk_end); end
            checks++; if (r.timeout !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout: got %b want 0", it, r.timeout); end
        end
    endtask

    initial begin
        test_reset();
        test_a4_oct4();
        test_a4_oct5();
        test_rest();
        test_zero_duration();
        test_reset_mid_note();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
